// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/memory-stage port arbiter and its read-return pipe.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   typedef enum logic {
      PRI_DM = 1'b0,
      PRI_IF = 1'b1
   } state_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
   } ret_tag_t;

endpackage

// File: rtl/mem_ret_pipe.sv
// Tag shift register tracking which requester owns each read in flight to memory.
// Latency: DEPTH cycles from push to tail.
// Backpressure: none; one entry shifts in every cycle, synchronous clear drops all tags.
module mem_ret_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic push_vld,
   input  logic push_owner,
   output logic tail_vld,
   output logic tail_owner
);

   ret_tag_t pipe_q [DEPTH];
   ret_tag_t pipe_d [DEPTH];

   always_comb begin
      pipe_d[0].vld   = push_vld;
      pipe_d[0].owner = push_owner ? OWN_DM : OWN_IF;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '{vld: 1'b0, owner: OWN_IF};
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign tail_vld   = pipe_q[DEPTH-1].vld;
   assign tail_owner = pipe_q[DEPTH-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and memory stage; DM priority with IF anti-starvation.
// Latency: grants combinational; read data returned MEM_LATENCY+1 edges after the grant.
// Backpressure: a requester without a grant stalls and must hold its request.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int MEM_LATENCY  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e            state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              push_vld, push_owner;
   logic              tail_vld, tail_owner;

   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (!reset) begin
         case (state_q)
            PRI_DM: begin
               dm_gnt = dm_req;
               if_gnt = if_req & ~dm_req;
            end
            PRI_IF: begin
               if_gnt = if_req;
               dm_gnt = dm_req & ~if_req;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_address = '0;
      mem_wren    = 1'b0;
      mem_data_in = '0;
      if (dm_gnt) begin
         mem_address = dm_addr;
         mem_wren    = dm_we;
         mem_data_in = dm_wdata;
      end else if (if_gnt) begin
         mem_address = if_addr;
      end
   end

   // The count that reaches the limit this cycle hands IF priority on the very next one.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      state_d      = state_q;
      if (if_gnt || !if_req) begin
         starve_cnt_d = 4'd0;
      end else if (dm_gnt && starve_cnt_q != 4'hF) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
      case (state_q)
         PRI_DM:  if (starve_cnt_d == LIMIT) state_d = PRI_IF;
         PRI_IF:  if (if_gnt || !if_req)     state_d = PRI_DM;
         default: state_d = PRI_DM;
      endcase
   end

   assign push_vld   = if_gnt | (dm_gnt & ~dm_we);
   assign push_owner = dm_gnt ? OWN_DM : OWN_IF;

   mem_ret_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_ret_pipe (
      .clock      (clock),
      .reset      (reset),
      .push_vld   (push_vld),
      .push_owner (push_owner),
      .tail_vld   (tail_vld),
      .tail_owner (tail_owner)
   );

   always_comb begin
      if_rvalid_d = tail_vld && (tail_owner == OWN_IF);
      dm_rvalid_d = tail_vld && (tail_owner == OWN_DM);
      if_rdata_d  = if_rvalid_d ? mem_data_out : if_rdata_q;
      dm_rdata_d  = dm_rvalid_d ? mem_data_out : dm_rdata_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= PRI_DM;
         starve_cnt_q <= 4'd0;
         if_rvalid_q  <= 1'b0;
         dm_rvalid_q  <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         if_rvalid_q  <= if_rvalid_d;
         dm_rvalid_q  <= dm_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign dm_rvalid = dm_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory controller.
// Latency: n/a.
// Backpressure: requests are held until granted or until reset.
module tb_mem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int MEM_LATENCY  = 1;
   localparam int RET          = MEM_LATENCY + 1;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req = 1'b0;
   logic              dm_we = 1'b0;
   logic [ADDR_W-1:0] dm_addr = '0;
   logic [DATA_W-1:0] dm_wdata = '0;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (STARVE_LIMIT),
      .MEM_LATENCY  (MEM_LATENCY)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .if_rdata     (if_rdata),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_gnt       (dm_gnt),
      .dm_rvalid    (dm_rvalid),
      .dm_rdata     (dm_rdata),
      .mem_address  (mem_address),
      .mem_wren     (mem_wren),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // Behavioural mem_controller: address sampled on an edge, data valid MEM_LATENCY cycles later.
   logic [31:0] mem [0:511];
   logic [31:0] rd_pipe [MEM_LATENCY];
   logic        mem_init = 1'b1;

   function automatic logic [31:0] preload(input int a);
      case (a)
         'h010:   return 32'h1111_0010;
         'h020:   return 32'h2222_0020;
         'h030:   return 32'h3333_0030;
         'h040:   return 32'hDEAD_BEEF;
         'h100:   return 32'hB00B_0100;
         'h1E0:   return 32'h5A5A_5A5A;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= preload(i);
      end else if (mem_wren) begin
         mem[mem_address[8:0]] <= mem_data_in;
      end
      rd_pipe[0] <= mem[mem_address[8:0]];
      for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data_out = rd_pipe[MEM_LATENCY-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic        own_dm;
      int          due;
      logic [31:0] data;
   } pend_t;
   pend_t pend[$];
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_dm_rdata = '0;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic        eig;
      logic        edg;
      logic [31:0] eaddr;
      logic        ewren;
      logic [31:0] edin;
   } vec_t;
   vec_t vecs[7];

   // A requester left waiting must still be requesting on the next cycle unless reset intervenes.
   logic if_wait = 1'b0;
   logic dm_wait = 1'b0;
   always @(negedge clock) begin
      if (!reset && if_wait) begin
         n_checks++;
         if (!if_req) begin
            n_fail++;
            $display("FAIL protocol_if: if_req dropped without grant at cycle %0d", cyc);
         end
      end
      if (!reset && dm_wait) begin
         n_checks++;
         if (!dm_req) begin
            n_fail++;
            $display("FAIL protocol_dm: dm_req dropped without grant at cycle %0d", cyc);
         end
      end
      if_wait = if_req & ~if_gnt & ~reset;
      dm_wait = dm_req & ~dm_gnt & ~reset;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step_drive(input logic rs, input logic ir, input logic [31:0] ia,
                             input logic dr, input logic dw, input logic [31:0] da,
                             input logic [31:0] dd);
      @(posedge clock);
      if (reset) begin
         pend.delete();
         exp_if_rdata = '0;
         exp_dm_rdata = '0;
      end
      cyc++;
      #1;
      reset    = rs;
      if_req   = ir;
      if_addr  = ia;
      dm_req   = dr;
      dm_we    = dw;
      dm_addr  = da;
      dm_wdata = dd;
      #2;
   endtask

   task automatic check_ret(input string tag);
      logic eiv;
      logic edv;
      eiv = 1'b0;
      edv = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].due == cyc) begin
            if (pend[i].own_dm) begin
               edv = 1'b1;
               exp_dm_rdata = pend[i].data;
            end else begin
               eiv = 1'b1;
               exp_if_rdata = pend[i].data;
            end
            pend.delete(i);
         end
      end
      chk({tag, " if_rvalid"}, {31'b0, if_rvalid}, {31'b0, eiv});
      chk({tag, " dm_rvalid"}, {31'b0, dm_rvalid}, {31'b0, edv});
      chk({tag, " if_rdata"},  if_rdata, exp_if_rdata);
      chk({tag, " dm_rdata"},  dm_rdata, exp_dm_rdata);
   endtask

   task automatic push(input logic eig, input logic edg, input logic dw, input logic [31:0] erd);
      if (eig) pend.push_back('{own_dm: 1'b0, due: cyc + RET, data: erd});
      else if (edg && !dw) pend.push_back('{own_dm: 1'b1, due: cyc + RET, data: erd});
   endtask

   task automatic cycle(input string tag, input logic rs, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic eig, input logic edg,
                        input logic [31:0] erd);
      logic [31:0] ea;
      logic [31:0] ed;
      step_drive(rs, ir, ia, dr, dw, da, dd);
      ea = edg ? da : (eig ? ia : 32'h0);
      ed = edg ? dd : 32'h0;
      chk({tag, " if_gnt"},      {31'b0, if_gnt},   {31'b0, eig});
      chk({tag, " dm_gnt"},      {31'b0, dm_gnt},   {31'b0, edg});
      chk({tag, " mem_address"}, mem_address,       ea);
      chk({tag, " mem_wren"},    {31'b0, mem_wren}, {31'b0, edg & dw});
      chk({tag, " mem_data_in"}, mem_data_in,       ed);
      check_ret(tag);
      push(eig, edg, dw, erd);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic rst_cycles(input int n);
      for (int i = 0; i < n; i++) cycle("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      //          ir    ia          dr    dw    da          dd           eig   edg   eaddr       ewren edin
      vecs[0] = '{1'b0, 32'h011,    1'b0, 1'b0, 32'h022,    32'h33,      1'b0, 1'b0, 32'h0,      1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h044,    1'b0, 1'b1, 32'h055,    32'hAAAA,    1'b1, 1'b0, 32'h044,    1'b0, 32'h0};
      vecs[2] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h088,    32'h5555,    1'b0, 1'b1, 32'h088,    1'b0, 32'h5555};
      vecs[3] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h09C,    32'hCAFE,    1'b0, 1'b1, 32'h09C,    1'b1, 32'hCAFE};
      vecs[4] = '{1'b1, 32'h104,    1'b1, 1'b1, 32'h108,    32'hF00D,    1'b0, 1'b1, 32'h108,    1'b1, 32'hF00D};
      vecs[5] = '{1'b1, 32'h10C,    1'b1, 1'b0, 32'h110,    32'h0,       1'b0, 1'b1, 32'h110,    1'b0, 32'h0};
      vecs[6] = '{1'b1, 32'h1FC,    1'b0, 1'b0, 32'h120,    32'hBEEF,    1'b1, 1'b0, 32'h1FC,    1'b0, 32'h0};

      @(posedge clock);
      #1 mem_init = 1'b0;
      rst_cycles(2);

      // Reset with an IF read in flight: the read must never come back.
      cycle("t1 if_rd",  1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'hB00B_0100);
      cycle("t1 in_rst", 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
      rst_cycles(1);
      idle("t1 after", 4);

      // Priority from idle, which also shows the FSM came out of reset in PRI_DM.
      cycle("t4 both",   1'b0, 1'b1, 32'h020, 1'b1, 1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 32'h1111_0010);
      cycle("t4 if",     1'b0, 1'b1, 32'h020, 1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h2222_0020);
      idle("t4 drain", 3);

      cycle("t2 if_rd",  1'b0, 1'b1, 32'h040, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      idle("t2 drain", 4);

      cycle("t3 wr",     1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h080, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
      cycle("t3 rd",     1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h080, 32'h0,         1'b0, 1'b1, 32'h1234_5678);
      idle("t3 drain", 4);

      cycle("t6 dm0",    1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 32'h0, 1'b0, 1'b1, 32'h1111_0010);
      cycle("t6 if1",    1'b0, 1'b1, 32'h020, 1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h2222_0020);
      cycle("t6 dm2",    1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h030, 32'h0, 1'b0, 1'b1, 32'h3333_0030);
      idle("t6 drain", 5);

      for (int v = 0; v < 7; v++) begin
         rst_cycles(1);
         step_drive(1'b0, vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dd);
         chk($sformatf("vec%0d if_gnt", v),      {31'b0, if_gnt},   {31'b0, vecs[v].eig});
         chk($sformatf("vec%0d dm_gnt", v),      {31'b0, dm_gnt},   {31'b0, vecs[v].edg});
         chk($sformatf("vec%0d mem_address", v), mem_address,       vecs[v].eaddr);
         chk($sformatf("vec%0d mem_wren", v),    {31'b0, mem_wren}, {31'b0, vecs[v].ewren});
         chk($sformatf("vec%0d mem_data_in", v), mem_data_in,       vecs[v].edin);
         check_ret($sformatf("vec%0d", v));
         push(vecs[v].eig, vecs[v].edg, vecs[v].dw, 32'h0);
      end
      rst_cycles(1);

      // Partial starvation run, then reset must clear the count.
      for (int k = 0; k < 3; k++) begin
         cycle("t5 pre", 1'b0, 1'b1, 32'h1E0, 1'b1, 1'b1, 32'h1F0, 32'(k), 1'b0, 1'b1, 32'h0);
      end
      rst_cycles(1);
      for (int k = 0; k < 10; k++) begin
         logic ig;
         ig = (k == 4) || (k == 9);
         cycle($sformatf("t5 starve%0d", k), 1'b0, 1'b1, 32'h1E0, 1'b1, 1'b1, 32'h1F0, 32'(k),
               ig, !ig, 32'h5A5A_5A5A);
      end
      rst_cycles(1);
      idle("t5 drain", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
